// File: rtl/id_decode_stage.sv
// Registered instruction-decode stage: turns a fetched instruction into ALU control
// (alufunc/shamt, operand select, register indices, immediate) with load-use interlock.
module id_decode_stage #(
    parameter logic [5:0] ALU_ADD = 6'b100000,
    parameter logic [5:0] ALU_SUB = 6'b100010,
    parameter logic [5:0] ALU_AND = 6'b100100,
    parameter logic [5:0] ALU_OR  = 6'b100101,
    parameter logic [5:0] ALU_XOR = 6'b100110,
    parameter logic [5:0] ALU_NOR = 6'b100111,
    parameter logic [5:0] ALU_SLT = 6'b101010,
    parameter logic [5:0] ALU_SLL = 6'b000000,
    parameter logic [5:0] ALU_SRL = 6'b000011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        instr_valid,
    output logic        in_ready,
    output logic        hazard_stall,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [5:0]  alufunc,
    output logic [4:0]  shamt,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dest,
    output logic [31:0] imm32,
    output logic        alu_src,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        branch,
    output logic        jump,
    output logic [25:0] jtarget,
    output logic        illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [5:0]  op, funct;
    logic [4:0]  f_rs, f_rt, f_rd, f_sh;
    logic [31:0] imm_sext, imm_zext;

    assign op       = instr_in[31:26];
    assign f_rs     = instr_in[25:21];
    assign f_rt     = instr_in[20:16];
    assign f_rd     = instr_in[15:11];
    assign f_sh     = instr_in[10:6];
    assign funct    = instr_in[5:0];
    assign imm_sext = {{16{instr_in[15]}}, instr_in[15:0]};
    assign imm_zext = {16'h0000, instr_in[15:0]};

    logic        dec_legal, dec_reads_rs, dec_reads_rt;
    logic [5:0]  dec_alufunc;
    logic [4:0]  dec_shamt, dec_dest;
    logic [31:0] dec_imm;
    logic        dec_alu_src, dec_reg_write, dec_mem_read, dec_mem_write;
    logic        dec_mem_to_reg, dec_branch, dec_jump;

    always_comb begin
        dec_legal      = 1'b1;
        dec_reads_rs   = (op != OP_J);
        dec_reads_rt   = 1'b0;
        dec_alufunc    = ALU_ADD;
        dec_shamt      = 5'd0;
        dec_dest       = 5'd0;
        dec_imm        = imm_sext;
        dec_alu_src    = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_reads_rt  = 1'b1;
                dec_dest      = f_rd;
                dec_reg_write = 1'b1;
                dec_imm       = 32'd0;
                case (funct)
                    6'b100000: dec_alufunc = ALU_ADD;
                    6'b100010: dec_alufunc = ALU_SUB;
                    6'b100100: dec_alufunc = ALU_AND;
                    6'b100101: dec_alufunc = ALU_OR;
                    6'b100110: dec_alufunc = ALU_XOR;
                    6'b100111: dec_alufunc = ALU_NOR;
                    6'b101010: dec_alufunc = ALU_SLT;
                    6'b000000: begin dec_alufunc = ALU_SLL; dec_shamt = f_sh; end
                    6'b000010: begin dec_alufunc = ALU_SRL; dec_shamt = f_sh; end
                    default:   dec_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                dec_dest      = f_rt;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                case (op)
                    OP_SLTI: dec_alufunc = ALU_SLT;
                    OP_ANDI: begin dec_alufunc = ALU_AND; dec_imm = imm_zext; end
                    OP_ORI:  begin dec_alufunc = ALU_OR;  dec_imm = imm_zext; end
                    OP_XORI: begin dec_alufunc = ALU_XOR; dec_imm = imm_zext; end
                    default: dec_alufunc = ALU_ADD;
                endcase
            end
            OP_LW: begin
                dec_dest       = f_rt;
                dec_alu_src    = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec_reads_rt  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_reads_rt = 1'b1;
                dec_alufunc  = ALU_SUB;
                dec_branch   = 1'b1;
            end
            OP_J:    dec_jump = 1'b1;
            default: dec_legal = 1'b0;
        endcase
        // Writes to r0 are architecturally dead; never request them.
        if (dec_dest == 5'd0)
            dec_reg_write = 1'b0;
    end

    logic        out_valid_q, out_valid_d;
    logic [5:0]  alufunc_q, alufunc_d;
    logic [4:0]  shamt_q, shamt_d, rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
    logic [31:0] imm32_q, imm32_d;
    logic        alu_src_q, alu_src_d, reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d, branch_q, branch_d, jump_q, jump_d;
    logic [25:0] jtarget_q, jtarget_d;
    logic        illegal_q, illegal_d;

    // Load on the outputs whose destination is read by the incoming instruction.
    always_comb begin
        hazard_stall = ~stall & ~flush & instr_valid & out_valid_q & mem_read_q &
                       (dest_q != 5'd0) &
                       ((dec_reads_rs & (f_rs == dest_q)) | (dec_reads_rt & (f_rt == dest_q)));
        in_ready = ~stall & ~hazard_stall;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        alufunc_d    = alufunc_q;
        shamt_d      = shamt_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        dest_d       = dest_q;
        imm32_d      = imm32_q;
        alu_src_d    = alu_src_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        branch_d     = branch_q;
        jump_d       = jump_q;
        jtarget_d    = jtarget_q;
        illegal_d    = 1'b0;
        if (flush || (!stall)) begin
            out_valid_d  = 1'b0;
            alu_src_d    = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            branch_d     = 1'b0;
            jump_d       = 1'b0;
            if (!flush && !hazard_stall && instr_valid) begin
                if (dec_legal) begin
                    out_valid_d  = 1'b1;
                    alufunc_d    = dec_alufunc;
                    shamt_d      = dec_shamt;
                    rs_d         = f_rs;
                    rt_d         = f_rt;
                    dest_d       = dec_dest;
                    imm32_d      = dec_imm;
                    alu_src_d    = dec_alu_src;
                    reg_write_d  = dec_reg_write;
                    mem_read_d   = dec_mem_read;
                    mem_write_d  = dec_mem_write;
                    mem_to_reg_d = dec_mem_to_reg;
                    branch_d     = dec_branch;
                    jump_d       = dec_jump;
                    jtarget_d    = instr_in[25:0];
                end else begin
                    illegal_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            alufunc_q    <= 6'd0;
            shamt_q      <= 5'd0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            dest_q       <= 5'd0;
            imm32_q      <= 32'd0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            jtarget_q    <= 26'd0;
            illegal_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            alufunc_q    <= alufunc_d;
            shamt_q      <= shamt_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            dest_q       <= dest_d;
            imm32_q      <= imm32_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            jtarget_q    <= jtarget_d;
            illegal_q    <= illegal_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alufunc    = alufunc_q;
    assign shamt      = shamt_q;
    assign rs         = rs_q;
    assign rt         = rt_q;
    assign dest       = dest_q;
    assign imm32      = imm32_q;
    assign alu_src    = alu_src_q;
    assign reg_write  = reg_write_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_to_reg = mem_to_reg_q;
    assign branch     = branch_q;
    assign jump       = jump_q;
    assign jtarget    = jtarget_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: expected decodes queued per step, checked after each edge.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst, instr_valid, stall, flush;
    logic [31:0] instr_in;
    logic        in_ready, hazard_stall, out_valid;
    logic [5:0]  alufunc;
    logic [4:0]  shamt, rs, rt, dest;
    logic [31:0] imm32;
    logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, jump, illegal;
    logic [25:0] jtarget;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_decode_stage dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .in_ready(in_ready), .hazard_stall(hazard_stall), .stall(stall), .flush(flush),
        .out_valid(out_valid), .alufunc(alufunc), .shamt(shamt), .rs(rs), .rt(rt),
        .dest(dest), .imm32(imm32), .alu_src(alu_src), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .branch(branch), .jump(jump), .jtarget(jtarget), .illegal(illegal)
    );

    // chk: [0] imm32, [1] jtarget, [2] rs/rt, [3] check fields even when out_valid=0
    typedef struct {
        logic        v;
        logic [5:0]  af;
        logic [4:0]  sh, rs, rt, dst;
        logic [31:0] imm;
        logic [25:0] jt;
        logic [3:0]  chk;
        logic [7:0]  fl;   // {alu_src,reg_write,mem_read,mem_write,mem_to_reg,branch,jump,illegal}
    } exp_t;

    exp_t sb[$];

    localparam logic [7:0] F_NONE = 8'b0000_0000;
    localparam logic [7:0] F_R    = 8'b0100_0000;
    localparam logic [7:0] F_I    = 8'b1100_0000;
    localparam logic [7:0] F_LW   = 8'b1110_1000;
    localparam logic [7:0] F_SW   = 8'b1001_0000;
    localparam logic [7:0] F_BEQ  = 8'b0000_0100;
    localparam logic [7:0] F_J    = 8'b0000_0010;
    localparam logic [7:0] F_ILL  = 8'b0000_0001;

    localparam logic [31:0] I_ADD3   = 32'h00221820;
    localparam logic [31:0] I_SRL    = 32'h00022142;
    localparam logic [31:0] I_ADDI   = 32'h2001FFFC;
    localparam logic [31:0] I_ORI    = 32'h3401FFFC;
    localparam logic [31:0] I_LW     = 32'h8C250008;
    localparam logic [31:0] I_ADD655 = 32'h00A53020;
    localparam logic [31:0] I_ADD612 = 32'h00223020;
    localparam logic [31:0] I_SW     = 32'hAC220004;
    localparam logic [31:0] I_BADOP  = 32'hFC000000;
    localparam logic [31:0] I_BADFN  = 32'h0000003F;
    localparam logic [31:0] I_ADD0   = 32'h00220020;
    localparam logic [31:0] I_BEQ    = 32'h10220003;
    localparam logic [31:0] I_J      = 32'h08000010;

    function automatic exp_t mk(input logic v, input logic [5:0] af, input logic [4:0] sh,
                                input logic [4:0] r_s, input logic [4:0] r_t, input logic [4:0] dst,
                                input logic [31:0] imm, input logic [25:0] jt,
                                input logic [3:0] chk, input logic [7:0] fl);
        exp_t e;
        e.v = v; e.af = af; e.sh = sh; e.rs = r_s; e.rt = r_t; e.dst = dst;
        e.imm = imm; e.jt = jt; e.chk = chk; e.fl = fl;
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        cmp("out_valid", 32'(out_valid), 32'(e.v));
        cmp("flags", 32'({alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, jump, illegal}),
            32'(e.fl));
        if (e.v || e.chk[3]) begin
            cmp("alufunc", 32'(alufunc), 32'(e.af));
            cmp("shamt", 32'(shamt), 32'(e.sh));
            cmp("dest", 32'(dest), 32'(e.dst));
            if (e.chk[2]) begin
                cmp("rs", 32'(rs), 32'(e.rs));
                cmp("rt", 32'(rt), 32'(e.rt));
            end
            if (e.chk[0]) cmp("imm32", imm32, e.imm);
            if (e.chk[1]) cmp("jtarget", 32'(jtarget), 32'(e.jt));
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        instr_in = ins; instr_valid = v; stall = st; flush = fl;
    endtask

    task automatic tick(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t zero, bub, e_add3, e_lw, e_add655, e_sw;
        zero     = mk(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0, 4'hF, F_NONE);
        bub      = mk(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0, 4'h0, F_NONE);
        e_add3   = mk(1'b1, 6'b100000, 5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 26'd0, 4'h4, F_R);
        e_lw     = mk(1'b1, 6'b100000, 5'd0, 5'd1, 5'd5, 5'd5, 32'd8, 26'd0, 4'h5, F_LW);
        e_add655 = mk(1'b1, 6'b100000, 5'd0, 5'd5, 5'd5, 5'd6, 32'd0, 26'd0, 4'h4, F_R);
        e_sw     = mk(1'b1, 6'b100000, 5'd0, 5'd1, 5'd2, 5'd0, 32'd4, 26'd0, 4'h5, F_SW);

        rst = 1'b1;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(zero);
        check_out();
        cmp("reset_hazard_stall", 32'(hazard_stall), 32'd0);
        rst = 1'b0;

        drive(I_ADD3, 1'b1, 1'b0, 1'b0);
        #1 cmp("add_in_ready", 32'(in_ready), 32'd1);
        tick(e_add3);

        drive(I_SRL, 1'b1, 1'b0, 1'b0);
        tick(mk(1'b1, 6'b000011, 5'd5, 5'd0, 5'd2, 5'd4, 32'd0, 26'd0, 4'h4, F_R));
        drive(I_ADDI, 1'b1, 1'b0, 1'b0);
        tick(mk(1'b1, 6'b100000, 5'd0, 5'd0, 5'd1, 5'd1, 32'hFFFFFFFC, 26'd0, 4'h5, F_I));
        drive(I_ORI, 1'b1, 1'b0, 1'b0);
        tick(mk(1'b1, 6'b100101, 5'd0, 5'd0, 5'd1, 5'd1, 32'h0000FFFC, 26'd0, 4'h5, F_I));

        // Load-use: one bubble, then the dependent ADD issues.
        drive(I_LW, 1'b1, 1'b0, 1'b0);
        tick(e_lw);
        drive(I_ADD655, 1'b1, 1'b0, 1'b0);
        #1;
        cmp("lu_hazard_stall", 32'(hazard_stall), 32'd1);
        cmp("lu_in_ready", 32'(in_ready), 32'd0);
        tick(bub);
        cmp("lu_hazard_clear", 32'(hazard_stall), 32'd0);
        cmp("lu_in_ready_back", 32'(in_ready), 32'd1);
        tick(e_add655);

        drive(I_LW, 1'b1, 1'b0, 1'b0);
        tick(e_lw);
        drive(I_ADD612, 1'b1, 1'b0, 1'b0);
        #1 cmp("indep_hazard_stall", 32'(hazard_stall), 32'd0);
        tick(mk(1'b1, 6'b100000, 5'd0, 5'd1, 5'd2, 5'd6, 32'd0, 26'd0, 4'h4, F_R));

        // Downstream stall holds the SW on the outputs.
        drive(I_SW, 1'b1, 1'b0, 1'b0);
        tick(e_sw);
        for (int i = 0; i < 3; i++) begin
            drive(I_ADD3, 1'b1, 1'b1, 1'b0);
            #1 cmp("stall_in_ready", 32'(in_ready), 32'd0);
            tick(e_sw);
        end
        drive(I_ADD3, 1'b1, 1'b0, 1'b0);
        tick(e_add3);

        drive(I_BEQ, 1'b1, 1'b0, 1'b0);
        tick(mk(1'b1, 6'b100010, 5'd0, 5'd1, 5'd2, 5'd0, 32'd3, 26'd0, 4'h5, F_BEQ));
        drive(I_J, 1'b1, 1'b0, 1'b0);
        tick(mk(1'b1, 6'b100000, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'h10, 4'h2, F_J));

        drive(I_BADOP, 1'b1, 1'b0, 1'b0);
        tick(mk(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0, 4'h0, F_ILL));
        drive(I_BADFN, 1'b1, 1'b0, 1'b0);
        tick(mk(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0, 4'h0, F_ILL));
        drive(I_ADD0, 1'b1, 1'b0, 1'b0);
        tick(mk(1'b1, 6'b100000, 5'd0, 5'd1, 5'd2, 5'd0, 32'd0, 26'd0, 4'h4, F_NONE));
        drive(32'd0, 1'b1, 1'b0, 1'b0);
        tick(mk(1'b1, 6'b000000, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0, 4'h4, F_NONE));
        drive(I_ADD3, 1'b0, 1'b0, 1'b0);
        tick(bub);

        // Flush during a hazard cycle squashes the output and the load tracking.
        drive(I_LW, 1'b1, 1'b0, 1'b0);
        tick(e_lw);
        drive(I_ADD655, 1'b1, 1'b0, 1'b0);
        #1 cmp("pre_flush_hazard", 32'(hazard_stall), 32'd1);
        flush = 1'b1;
        #1 cmp("flush_gates_hazard", 32'(hazard_stall), 32'd0);
        tick(bub);
        flush = 1'b0;
        #1 cmp("post_flush_hazard", 32'(hazard_stall), 32'd0);
        tick(e_add655);

        // Reset in the middle of a hazard.
        drive(I_LW, 1'b1, 1'b0, 1'b0);
        tick(e_lw);
        drive(I_ADD655, 1'b1, 1'b0, 1'b0);
        #1 cmp("pre_rst_hazard", 32'(hazard_stall), 32'd1);
        rst = 1'b1;
        tick(zero);
        rst = 1'b0;
        #1;
        cmp("post_rst_hazard", 32'(hazard_stall), 32'd0);
        cmp("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick(e_add655);

        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered instruction-decode stage that produces the ALU's control inputs: alufunc, shamt, operand selects, register indices, immediate.
- Sits between fetch and the execute stage that contains the ALU. It is the producing end of the alufunc/shamt interface.
- Adds load-use hazard detection (one-bubble insertion), downstream stall, flush and illegal-instruction flagging.

Parameters:
- ALU_ADD, 6'b100000, alufunc code for add
- ALU_SUB, 6'b100010, alufunc code for subtract
- ALU_AND, 6'b100100, alufunc code for AND
- ALU_OR, 6'b100101, alufunc code for OR
- ALU_XOR, 6'b100110, alufunc code for XOR
- ALU_NOR, 6'b100111, alufunc code for NOR
- ALU_SLT, 6'b101010, alufunc code for set-less-than
- ALU_SLL, 6'b000000, alufunc code for shift left
- ALU_SRL, 6'b000011, alufunc code for shift right

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- instr_in  in  32  fetched instruction
- instr_valid  in  1  instr_in is valid this cycle
- in_ready  out  1  instruction consumed this cycle: ~stall & ~hazard_stall
- hazard_stall  out  1  combinational load-use stall request to fetch
- stall  in  1  downstream stall; hold all outputs
- flush  in  1  squash the output register and the in-flight decode
- out_valid  out  1  decoded fields valid
- alufunc  out  6  ALU function code
- shamt  out  5  shift amount, instr[10:6]; 0 for non-shift ops
- rs  out  5  source register index A
- rt  out  5  source register index B
- dest  out  5  write-back register index
- imm32  out  32  extended immediate
- alu_src  out  1  1 = ALU B operand is imm32
- reg_write, mem_read, mem_write, mem_to_reg, branch, jump  out  1 each  control flags
- jtarget  out  26  instr[25:0]
- illegal  out  1  one-cycle pulse: undefined opcode or funct consumed

Behaviour:
- Reset (rst=1 at edge): every output register cleared to 0 (out_valid=0, alufunc=6'b000000, imm32=0, all flags 0, illegal=0). Load-tracking state is cleared.
- Latency: 1 cycle. An instruction consumed at edge N appears on the outputs after edge N.
- Priority at each edge: rst > flush > stall > hazard > normal.
  - flush: out_valid<=0, illegal<=0, load tracking cleared.
  - stall=1 (no flush): all outputs hold; instruction not consumed.
- Hazard rule:
  - Condition: out_valid=1 & mem_read=1 & dest!=0, and a valid instr_in reads dest.
  - rs counts as read for every format except J. rt counts as read for R-type, SW and BEQ.
  - When the condition holds: hazard_stall=1 combinationally and in_ready=0. Next edge loads a bubble (out_valid=0, all flags 0).
  - The following cycle the condition is false and the instruction issues.
  - hazard_stall is gated to 0 while stall=1 or flush=1.
- R-type (op=000000), ALU funct mapping:
  - 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 100110->XOR, 100111->NOR, 101010->SLT.
  - 000000->SLL, 000010->SRL (drives ALU_SRL=000011); shifts pass instr[10:6] on shamt.
  - R-type fields: dest=rd, reg_write=1, alu_src=0.
- R-type, any other funct: illegal=1, out_valid=0, all flags 0.
- I-type mapping:
  - ADDI 001000->ADD, sign-extended imm.
  - SLTI 001010->SLT, sign-extended imm.
  - ANDI 001100, ORI 001101, XORI 001110: zero-extended imm.
  - All of the above: dest=rt, alu_src=1, reg_write=1.
- LW 100011: ADD, sign-ext, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, dest=rt.
- SW 101011: ADD, sign-ext, alu_src=1, mem_write=1, reg_write=0.
- BEQ 000100: SUB, alu_src=0, branch=1, sign-ext imm; the downstream stage does the shift.
- J 000010: jump=1, jtarget=instr[25:0], reg_write=0, alufunc=ADD.
- Any other opcode: illegal pulse, bubble.
- reg_write is forced to 0 whenever dest=0. The all-zero NOP is out_valid=1, reg_write=0.
- instr_valid=0 with in_ready=1: bubble loaded (out_valid=0).
- Reset mid-hazard or mid-stall: outputs clear, hazard_stall drops to 0 in the cycle after reset.

Test Plan:
- ADD r3,r1,r2 (0x00221820), valid, no stall -> next cycle out_valid=1, alufunc=100000, rs=1, rt=2, dest=3, reg_write=1, alu_src=0, shamt=0.
- SRL r4,r2,5 (0x00022142) -> alufunc=000011, shamt=5, rt=2, dest=4. Then ADDI r1,r0,-4 (0x2001FFFC) -> imm32=0xFFFFFFFC, alu_src=1, alufunc=100000. Then ORI r1,r0,0xFFFC (0x3401FFFC) -> imm32=0x0000FFFC, alufunc=100101.
- LW r5,8(r1) (0x8C250008) followed by ADD r6,r5,r5 (0x00A53020):
  - While LW is on the outputs: hazard_stall=1, in_ready=0 for exactly one cycle.
  - Next cycle: bubble (out_valid=0).
  - Following cycle: ADD issues with dest=6.
  - LW then ADD r6,r1,r2 produces no stall.
- stall=1 for 3 cycles with SW r2,4(r1) (0xAC220004) on the outputs -> outputs constant (mem_write=1, reg_write=0), in_ready=0. Then the next instruction issues.
- Opcode 0xFC000000, and R-type funct 0x3F (0x0000003F) -> illegal=1 for one cycle, out_valid=0. ADD r0,r1,r2 (0x00220020) -> out_valid=1, reg_write=0.
- flush asserted during a hazard_stall cycle -> out_valid=0, hazard_stall=0 next cycle. rst asserted mid-stream -> all outputs 0 after the edge.
